// File: rtl/vx_mem_tag_issuer_pkg.sv
// Shared constants and types for the memory tag issuer.
// Also provides the VX_LOG2UP width-derivation macro used for tag widths.
`ifndef VX_LOG2UP
`define VX_LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

package vx_mem_tag_issuer_pkg;

    localparam int PERF_CNT_W = 32;

    typedef logic [PERF_CNT_W-1:0] perf_cnt_t;

endpackage

// File: rtl/vx_mem_tag_issuer_chk.sv
// Simulation checks for tag bookkeeping: no release of a free tag,
// no allocation of a tag that is still outstanding.
module vx_mem_tag_issuer_chk #(
    parameter int NUM_TAGS = 8,
    parameter int TAG_W    = `VX_LOG2UP(NUM_TAGS)
) (
    input logic                clk,
    input logic                reset,
    input logic [NUM_TAGS-1:0] free_mask,
    input logic                alloc,
    input logic [TAG_W-1:0]    alloc_tag,
    input logic                rel,
    input logic [TAG_W-1:0]    rel_tag
);

    rsp_tag_outstanding_a: assert property (@(posedge clk) disable iff (reset)
        rel |-> !free_mask[rel_tag]);

    alloc_tag_free_a: assert property (@(posedge clk) disable iff (reset)
        alloc |-> free_mask[alloc_tag]);

endmodule

// File: rtl/vx_mem_tag_issuer_lzc.sv
// Lowest-set-bit finder used to pick the next free tag.
// cnt is the index of the lowest set bit of in_vec; valid is low when in_vec is zero.
module vx_lzc #(
    parameter int N = 8,
    parameter int W = `VX_LOG2UP(N)
) (
    input  logic [N-1:0] in_vec,
    output logic [W-1:0] cnt,
    output logic         valid
);

    // Scan from the top so the lowest set index is the last one written
    always_comb begin
        cnt = {W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            cnt = in_vec[i] ? W'(i) : cnt;
        end
        valid = |in_vec;
    end

endmodule

// File: rtl/vx_mem_tag_issuer_ram.sv
// Dual-port LUTRAM: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module vx_dp_ram #(
    parameter int DATAW = 8,
    parameter int SIZE  = 8,
    parameter int ADDRW = `VX_LOG2UP(SIZE)
) (
    input  logic             clk,
    input  logic             wren,
    input  logic [ADDRW-1:0] waddr,
    input  logic [DATAW-1:0] wdata,
    input  logic [ADDRW-1:0] raddr,
    output logic [DATAW-1:0] rdata
);

    logic [DATAW-1:0] mem_r [SIZE];

    // Write port
    always_ff @(posedge clk) begin
        if (wren) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/vx_mem_tag_issuer.sv
// Memory tag issuer: allocates a tag per request, remembers its metadata and
// returns it with the response. Define VX_MEM_TAG_PERF_EN for perf counters.
module vx_mem_tag_issuer
    import vx_mem_tag_issuer_pkg::*;
#(
    parameter int REQ_DATAW = 32,
    parameter int RSP_DATAW = 32,
    parameter int META_W    = 8,
    parameter int NUM_TAGS  = 8,
    parameter int TAG_W     = `VX_LOG2UP(NUM_TAGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [REQ_DATAW-1:0] req_data,
    input  logic [META_W-1:0]    req_meta,
    output logic                 req_ready,
    output logic                 mem_req_valid,
    output logic [REQ_DATAW-1:0] mem_req_data,
    output logic [TAG_W-1:0]     mem_req_tag,
    input  logic                 mem_req_ready,
    input  logic                 mem_rsp_valid,
    input  logic [RSP_DATAW-1:0] mem_rsp_data,
    input  logic [TAG_W-1:0]     mem_rsp_tag,
    output logic                 mem_rsp_ready,
    output logic                 rsp_valid,
    output logic [RSP_DATAW-1:0] rsp_data,
    output logic [META_W-1:0]    rsp_meta,
    input  logic                 rsp_ready,
`ifdef VX_MEM_TAG_PERF_EN
    output logic                 busy,
    output logic [PERF_CNT_W-1:0] perf_reqs,
    output logic [PERF_CNT_W-1:0] perf_stalls
`else
    output logic                 busy
`endif
);

    logic [NUM_TAGS-1:0]  free_mask_r;
    logic [NUM_TAGS-1:0]  free_next_s;
    logic [NUM_TAGS-1:0]  alloc_mask_s;
    logic [NUM_TAGS-1:0]  release_mask_s;
    logic [TAG_W-1:0]     sel_tag_r;
    logic [TAG_W-1:0]     sel_tag_s;
    logic                 sel_valid_s;
    logic                 full_r;
    logic                 busy_r;
    logic                 alloc_s;
    logic                 release_s;
    logic                 mem_req_valid_r;
    logic [REQ_DATAW-1:0] mem_req_data_r;
    logic [TAG_W-1:0]     mem_req_tag_r;
    logic                 rsp_valid_r;
    logic [RSP_DATAW-1:0] rsp_data_r;
    logic [META_W-1:0]    rsp_meta_r;
    logic [META_W-1:0]    rd_meta_s;

    assign req_ready     = ~full_r & (~mem_req_valid_r | mem_req_ready);
    assign mem_rsp_ready = ~rsp_valid_r | rsp_ready;
    assign alloc_s       = req_valid & req_ready;
    assign release_s     = mem_rsp_valid & mem_rsp_ready;

    // Next free mask: clear the allocated tag, set the released one
    always_comb begin
        alloc_mask_s   = {NUM_TAGS{1'b0}};
        release_mask_s = {NUM_TAGS{1'b0}};
        for (int i = 0; i < NUM_TAGS; i++) begin
            alloc_mask_s[i]   = alloc_s & (sel_tag_r == TAG_W'(i));
            release_mask_s[i] = release_s & (mem_rsp_tag == TAG_W'(i));
        end
        free_next_s = (free_mask_r & ~alloc_mask_s) | release_mask_s;
    end

    vx_lzc #(
        .N (NUM_TAGS),
        .W (TAG_W)
    ) free_lzc (
        .in_vec (free_next_s),
        .cnt    (sel_tag_s),
        .valid  (sel_valid_s)
    );

    // Tag state; selection and full flag come from the next-state mask so a
    // released tag is usable the cycle after release
    always_ff @(posedge clk) begin
        if (reset) begin
            free_mask_r <= {NUM_TAGS{1'b1}};
            sel_tag_r   <= {TAG_W{1'b0}};
            full_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            free_mask_r <= free_next_s;
            sel_tag_r   <= sel_tag_s;
            full_r      <= ~sel_valid_s;
            busy_r      <= ~&free_next_s;
        end
    end

    vx_dp_ram #(
        .DATAW (META_W),
        .SIZE  (NUM_TAGS),
        .ADDRW (TAG_W)
    ) meta_ram (
        .clk   (clk),
        .wren  (alloc_s),
        .waddr (sel_tag_r),
        .wdata (req_meta),
        .raddr (mem_rsp_tag),
        .rdata (rd_meta_s)
    );

    // Memory request valid: set on accept, cleared once memory takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_valid_r <= 1'b0;
        end else if (alloc_s) begin
            mem_req_valid_r <= 1'b1;
        end else if (mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
        end else begin
            mem_req_valid_r <= mem_req_valid_r;
        end
    end

    // Memory request payload; only loads when the slot is free or draining
    always_ff @(posedge clk) begin
        if (alloc_s) begin
            mem_req_data_r <= req_data;
            mem_req_tag_r  <= sel_tag_r;
        end
    end

    // Upstream response valid, in memory arrival order
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
        end else if (release_s) begin
            rsp_valid_r <= 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    // Upstream response payload with the metadata looked up by tag
    always_ff @(posedge clk) begin
        if (release_s) begin
            rsp_data_r <= mem_rsp_data;
            rsp_meta_r <= rd_meta_s;
        end
    end

    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_data  = mem_req_data_r;
    assign mem_req_tag   = mem_req_tag_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_meta      = rsp_meta_r;
    assign busy          = busy_r;

`ifdef VX_MEM_TAG_PERF_EN
    perf_cnt_t perf_reqs_r;
    perf_cnt_t perf_stalls_r;

    // Accepted-request and stalled-cycle counters, free-running wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_reqs_r   <= {PERF_CNT_W{1'b0}};
            perf_stalls_r <= {PERF_CNT_W{1'b0}};
        end else begin
            perf_reqs_r   <= perf_reqs_r + PERF_CNT_W'(alloc_s);
            perf_stalls_r <= perf_stalls_r + PERF_CNT_W'(req_valid & ~req_ready);
        end
    end

    assign perf_reqs   = perf_reqs_r;
    assign perf_stalls = perf_stalls_r;
`endif

    vx_mem_tag_issuer_chk #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) tag_chk (
        .clk       (clk),
        .reset     (reset),
        .free_mask (free_mask_r),
        .alloc     (alloc_s),
        .alloc_tag (sel_tag_r),
        .rel       (release_s),
        .rel_tag   (mem_rsp_tag)
    );

endmodule

// File: tb/tb_vx_mem_tag_issuer.sv
// Self-checking bench for vx_mem_tag_issuer: directed vector table, corner
// sequences and randomized traffic against a tag-pool reference model.
module tb_vx_mem_tag_issuer;

    localparam int NT = 8;
    localparam int TW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_data;
    logic [7:0]  req_meta;
    logic        req_ready;
    logic        mem_req_valid;
    logic [31:0] mem_req_data;
    logic [TW-1:0] mem_req_tag;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [TW-1:0] mem_rsp_tag;
    logic        mem_rsp_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_meta;
    logic        rsp_ready;
    logic        busy;
`ifdef VX_MEM_TAG_PERF_EN
    logic [31:0] perf_reqs;
    logic [31:0] perf_stalls;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    vx_mem_tag_issuer dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_meta      (req_meta),
        .req_ready     (req_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_data  (mem_req_data),
        .mem_req_tag   (mem_req_tag),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_tag   (mem_rsp_tag),
        .mem_rsp_ready (mem_rsp_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_meta      (rsp_meta),
        .rsp_ready     (rsp_ready),
`ifdef VX_MEM_TAG_PERF_EN
        .perf_reqs     (perf_reqs),
        .perf_stalls   (perf_stalls),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference model: pool of free tags, metadata per tag, one pending
    // memory request slot, one response slot, tags held by the memory
    bit          free_m [NT];
    bit          in_mem [NT];
    logic [7:0]  meta_m [NT];
    bit          pend_v;
    logic [31:0] pend_d;
    logic [TW-1:0] pend_t;
    bit          rv_v;
    logic [31:0] rv_d;
    logic [7:0]  rv_m;
    logic [31:0] m_reqs;
    logic [31:0] m_stalls;

    typedef struct packed {
        bit       rv;
        bit [7:0] meta;
        bit       rspv;
        bit [2:0] rtag;
        bit       e_rdy;
        bit       e_mrv;
        bit [2:0] e_tag;
        bit       e_rsv;
        bit [7:0] e_meta;
        bit       e_busy;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(bit rv, bit [7:0] meta, bit rspv, bit [2:0] rtag,
                                bit e_rdy, bit e_mrv, bit [2:0] e_tag,
                                bit e_rsv, bit [7:0] e_meta, bit e_busy);
        vec_t v;
        v.rv = rv; v.meta = meta; v.rspv = rspv; v.rtag = rtag;
        v.e_rdy = e_rdy; v.e_mrv = e_mrv; v.e_tag = e_tag;
        v.e_rsv = e_rsv; v.e_meta = e_meta; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int low_free();
        for (int i = 0; i < NT; i++) begin
            if (free_m[i]) return i;
        end
        return -1;
    endfunction

    function automatic int n_free();
        int n = 0;
        for (int i = 0; i < NT; i++) n += int'(free_m[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            free_m[i] = 1'b1;
            in_mem[i] = 1'b0;
        end
        pend_v = 1'b0;
        rv_v = 1'b0;
        m_reqs = 32'd0;
        m_stalls = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0; req_data = 32'd0; req_meta = 8'd0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
        mem_rsp_tag = 3'd0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, compare against the model, advance the model
    task automatic cyc(input bit rv, input logic [7:0] meta, input logic [31:0] rdata,
                       input bit mrr, input bit rspv, input logic [TW-1:0] rtag,
                       input logic [31:0] rspdata, input bit rr);
        int  lf;
        bit  e_rdy;
        bit  e_mrr;
        bit  acc_q;
        bit  acc_r;
        req_valid = rv; req_meta = meta; req_data = rdata; mem_req_ready = mrr;
        mem_rsp_valid = rspv; mem_rsp_tag = rtag; mem_rsp_data = rspdata; rsp_ready = rr;
        #2;
        lf = low_free();
        e_rdy = (lf >= 0) && (!pend_v || mrr);
        e_mrr = !rv_v || rr;
        chk("req_ready", 64'(req_ready), 64'(e_rdy));
        chk("mem_req_valid", 64'(mem_req_valid), 64'(pend_v));
        if (pend_v) begin
            chk("mem_req_data", 64'(mem_req_data), 64'(pend_d));
            chk("mem_req_tag", 64'(mem_req_tag), 64'(pend_t));
        end
        chk("mem_rsp_ready", 64'(mem_rsp_ready), 64'(e_mrr));
        chk("rsp_valid", 64'(rsp_valid), 64'(rv_v));
        if (rv_v) begin
            chk("rsp_data", 64'(rsp_data), 64'(rv_d));
            chk("rsp_meta", 64'(rsp_meta), 64'(rv_m));
        end
        chk("busy", 64'(busy), 64'(n_free() != NT));
`ifdef VX_MEM_TAG_PERF_EN
        chk("perf_reqs", 64'(perf_reqs), 64'(m_reqs));
        chk("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
`endif
        acc_q = rv && e_rdy;
        acc_r = rspv && e_mrr;
        m_reqs = m_reqs + 32'(acc_q);
        m_stalls = m_stalls + 32'(rv && !e_rdy);
        if (pend_v && mrr) in_mem[pend_t] = 1'b1;
        if (acc_q) begin
            pend_v = 1'b1; pend_d = rdata; pend_t = lf[TW-1:0];
            free_m[lf] = 1'b0; meta_m[lf] = meta;
        end else if (mrr) begin
            pend_v = 1'b0;
        end
        if (acc_r) begin
            rv_v = 1'b1; rv_d = rspdata; rv_m = meta_m[rtag];
            free_m[rtag] = 1'b1; in_mem[rtag] = 1'b0;
        end else if (rr) begin
            rv_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] r2;
        int          pick;
        int          q[$];
        bit          rspv;

        // Directed table: single round trip, then fill all tags and free tag 3
        tbl[0] = mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
        tbl[1] = mk(1'b1, 8'h5A, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
        tbl[2] = mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1);
        tbl[3] = mk(1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1);
        tbl[4] = mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h5A, 1'b0);
        tbl[5] = mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tbl[6 + i] = mk(1'b1, 8'h10 + 8'(i), 1'b0, 3'd0, 1'b1, i > 0,
                            3'(i - 1), 1'b0, 8'h00, i > 0);
        end
        tbl[14] = mk(1'b1, 8'h99, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7, 1'b0, 8'h00, 1'b1);
        tbl[15] = mk(1'b1, 8'h99, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1);
        tbl[16] = mk(1'b1, 8'h99, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h13, 1'b1);
        tbl[17] = mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 1'b1);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            req_valid = tbl[i].rv; req_meta = tbl[i].meta; req_data = {24'hA00000, tbl[i].meta};
            mem_rsp_valid = tbl[i].rspv; mem_rsp_tag = tbl[i].rtag;
            mem_rsp_data = {29'h1BADF00, tbl[i].rtag};
            mem_req_ready = 1'b1; rsp_ready = 1'b1;
            #2;
            chk($sformatf("tbl%0d.req_ready", i), 64'(req_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d.mem_req_valid", i), 64'(mem_req_valid), 64'(tbl[i].e_mrv));
            if (tbl[i].e_mrv) chk($sformatf("tbl%0d.mem_req_tag", i), 64'(mem_req_tag), 64'(tbl[i].e_tag));
            chk($sformatf("tbl%0d.rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].e_rsv));
            if (tbl[i].e_rsv) chk($sformatf("tbl%0d.rsp_meta", i), 64'(rsp_meta), 64'(tbl[i].e_meta));
            chk($sformatf("tbl%0d.busy", i), 64'(busy), 64'(tbl[i].e_busy));
            @(posedge clk);
            #1;
        end

        // Fill all tags, answer out of order 5,1,7
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'hC0 + 8'(i), 32'h100 + 32'(i), 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b1, 3'd5, 32'h5555, 1'b1);
        cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b1, 3'd1, 32'h1111, 1'b1);
        cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b1, 3'd7, 32'h7777, 1'b1);
        cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        // One free tag left, then allocate and release in the same cycle
        cyc(1'b1, 8'hE1, 32'h201, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        cyc(1'b1, 8'hE5, 32'h205, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        cyc(1'b1, 8'hE7, 32'h207, 1'b1, 1'b1, 3'd0, 32'hAAAA, 1'b1);
        cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        cyc(1'b1, 8'hE0, 32'h200, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);

        // Back-pressure on both sides
        do_reset();
        cyc(1'b1, 8'h3C, 32'hCAFE0001, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h44, 32'h0BAD0000, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b1, 3'd0, 32'hFEED0000, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0);
        cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);

        // Random traffic; memory only answers tags it has actually received
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            q.delete();
            for (int i = 0; i < NT; i++) begin
                if (in_mem[i]) q.push_back(i);
            end
            rspv = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            pick = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)] : 0;
            r0 = $urandom; r1 = $urandom; r2 = $urandom;
            cyc($urandom_range(0, 9) < 6, r0[7:0], r1, $urandom_range(0, 9) < 7,
                rspv, pick[TW-1:0], r2, $urandom_range(0, 9) < 7);
        end

        // Reset while busy: everything returns to idle
        do_reset();
        cyc(1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
